// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 digest readout path: FSM states, buffer
// address map and the host byte-order helper.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_PRIME,
    ST_PRESENT
  } readout_state_t;

  localparam int         DIGEST_WORDS      = 8;
  localparam logic [3:0] DIGEST_ADDR_IDLE  = 4'd0;
  localparam logic [3:0] DIGEST_ADDR_FIRST = 4'd1;
  localparam logic [3:0] DIGEST_ADDR_LAST  = 4'd8;

  // Reverses byte order so a little-endian host sees words in its native order.
  function automatic logic [31:0] byte_swap32(input logic [31:0] word);
    return {word[7:0], word[15:8], word[23:16], word[31:24]};
  endfunction

endpackage

// File: rtl/digest_readout_ctrl.sv
// Drains the eight digest words from output_buffer onto a valid/ready stream.
// Define DIGEST_READOUT_BSWAP_EN to present words byte-reversed for a little-endian host.
import sha256_pkg::*;

module digest_readout_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hash_done,
  input  logic [31:0] buf_data,
  output logic        buf_en,
  output logic [3:0]  buf_addr,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy,
  output logic        overrun
);

  readout_state_t state;
  logic [3:0]     k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      k          <= DIGEST_ADDR_IDLE;
      buf_en     <= 1'b0;
      buf_addr   <= DIGEST_ADDR_IDLE;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      buf_en <= 1'b0;
      // A new digest mid-readout is dropped so the buffer is never overwritten.
      if (hash_done && state != ST_IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          buf_addr   <= DIGEST_ADDR_IDLE;
          dout_valid <= 1'b0;
          dout_last  <= 1'b0;
          if (hash_done) begin
            state   <= ST_CAPTURE;
            buf_en  <= 1'b1;
            busy    <= 1'b1;
            overrun <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          k        <= DIGEST_ADDR_FIRST;
          buf_addr <= DIGEST_ADDR_FIRST;
          state    <= ST_PRIME;
        end
        // The buffer output is registered, so word k appears one cycle after its address.
        ST_PRIME: begin
          state      <= ST_PRESENT;
          dout_valid <= 1'b1;
          dout_last  <= (k == DIGEST_ADDR_LAST);
        end
        ST_PRESENT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (k == DIGEST_ADDR_LAST) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              k        <= DIGEST_ADDR_IDLE;
              buf_addr <= DIGEST_ADDR_IDLE;
            end else begin
              k        <= k + 4'd1;
              buf_addr <= k + 4'd1;
              state    <= ST_PRIME;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DIGEST_READOUT_BSWAP_EN
  assign dout = dout_valid ? byte_swap32(buf_data) : 32'd0;
`else
  assign dout = dout_valid ? buf_data : 32'd0;
`endif

endmodule

// File: tb/tb_digest_readout_ctrl.sv
// Bench for digest_readout_ctrl with a behavioural output_buffer and a
// word-stream reference model (expected words, handshake latency, overrun flag).
module tb_digest_readout_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hash_done = 1'b0;
  logic        dout_ready = 1'b0;
  logic [31:0] buf_data;
  logic        buf_en;
  logic [3:0]  buf_addr;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        busy;
  logic        overrun;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] in_words [8];
  logic [31:0] buf_regs [8];
  logic [31:0] out_var = 32'd0;

  digest_readout_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hash_done  (hash_done),
    .buf_data   (buf_data),
    .buf_en     (buf_en),
    .buf_addr   (buf_addr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // output_buffer stand-in: capture on en, registered read, address 0 reads zero.
  always @(posedge clk) begin
    if (buf_en) begin
      for (int i = 0; i < 8; i++) buf_regs[i] <= in_words[i];
    end
    if (buf_addr >= 4'd1 && buf_addr <= 4'd8) out_var <= buf_regs[int'(buf_addr) - 1];
    else out_var <= 32'd0;
  end
  assign buf_data = out_var;

  function automatic logic [31:0] host_word(input logic [31:0] x);
    logic [31:0] r;
`ifdef DIGEST_READOUT_BSWAP_EN
    r = {<<8{x}};
`else
    r = x;
`endif
    return r;
  endfunction

  task automatic load_iv();
    in_words[0] = 32'h6a09e667; in_words[1] = 32'hbb67ae85;
    in_words[2] = 32'h3c6ef372; in_words[3] = 32'ha54ff53a;
    in_words[4] = 32'h510e527f; in_words[5] = 32'h9b05688c;
    in_words[6] = 32'h1f83d9ab; in_words[7] = 32'h5be0cd19;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) in_words[i] = $urandom;
  endtask

  // One digest readout checked cycle by cycle against the word-stream model.
  // Cycle 0 is the hash_done cycle; word n may be presented 2 cycles after the
  // previous handshake (first word in cycle 3). Negative indices disable options.
  task automatic run_readout(input int stall_word, input int stall_len, input bit rand_ready,
                             input int inject_word, input int reset_word);
    logic [31:0] exp_q[$];
    logic [31:0] exp_dout;
    logic [3:0]  exp_addr;
    int cyc, widx, next_valid, stall_left;
    bit finished, exp_valid, exp_ovr, ovr_next, injected;
    for (int i = 0; i < 8; i++) exp_q.push_back(host_word(in_words[i]));
    widx = 0; next_valid = 3; stall_left = stall_len;
    finished = 0; exp_ovr = 0; ovr_next = 0; injected = 0;
    @(negedge clk);
    hash_done = 1'b1;
    dout_ready = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      hash_done = 1'b0;
      cyc++;
      if (ovr_next) exp_ovr = 1;
      exp_valid = !finished && cyc >= next_valid;
      exp_dout  = exp_valid ? exp_q[widx] : 32'd0;
      exp_addr  = (finished || cyc == 1) ? 4'd0 : 4'(widx + 1);
      compared += 7;
      if (dout_valid !== exp_valid) begin
        mismatched++;
        $display("[TB] FAIL dout_valid cycle %0d: got %b expected %b", cyc, dout_valid, exp_valid);
      end
      if (dout !== exp_dout) begin
        mismatched++;
        $display("[TB] FAIL dout cycle %0d: got %h expected %h", cyc, dout, exp_dout);
      end
      if (dout_last !== (exp_valid && widx == 7)) begin
        mismatched++;
        $display("[TB] FAIL dout_last cycle %0d: got %b expected %b", cyc, dout_last, exp_valid && widx == 7);
      end
      if (buf_en !== (cyc == 1)) begin
        mismatched++;
        $display("[TB] FAIL buf_en cycle %0d: got %b expected %b", cyc, buf_en, cyc == 1);
      end
      if (buf_addr !== exp_addr) begin
        mismatched++;
        $display("[TB] FAIL buf_addr cycle %0d: got %0d expected %0d", cyc, buf_addr, exp_addr);
      end
      if (busy !== !finished) begin
        mismatched++;
        $display("[TB] FAIL busy cycle %0d: got %b expected %b", cyc, busy, !finished);
      end
      if (overrun !== exp_ovr) begin
        mismatched++;
        $display("[TB] FAIL overrun cycle %0d: got %b expected %b", cyc, overrun, exp_ovr);
      end
      if (finished) begin
        dout_ready = 1'b0;
        return;
      end
      if (exp_valid && widx == reset_word) begin
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({buf_en, buf_addr, dout, dout_valid, dout_last, busy, overrun} !== 41'd0) begin
          mismatched++;
          $display("[TB] FAIL async_reset cycle %0d: got en=%b addr=%0d dout=%h v=%b l=%b busy=%b ovr=%b expected all zero",
                   cyc, buf_en, buf_addr, dout, dout_valid, dout_last, busy, overrun);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dout_ready = 1'b0;
        return;
      end
      if (exp_valid && widx == stall_word && stall_left > 0) begin
        dout_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        dout_ready = 1'($urandom_range(0, 1));
      end else begin
        dout_ready = 1'b1;
      end
      if (exp_valid && widx == inject_word && !injected) begin
        hash_done = 1'b1;
        injected = 1;
        ovr_next = 1;
        load_random();
      end
      if (exp_valid && dout_ready) begin
        widx++;
        next_valid = cyc + 2;
        if (widx == 8) finished = 1;
      end
    end
    mismatched++;
    $display("[TB] FAIL timeout: readout incomplete after %0d cycles, %0d of 8 words", cyc, widx);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    #1;
    compared++;
    if ({buf_en, buf_addr, dout, dout_valid, dout_last, busy, overrun} !== 41'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got en=%b addr=%0d dout=%h v=%b l=%b busy=%b ovr=%b expected all zero",
               buf_en, buf_addr, dout, dout_valid, dout_last, busy, overrun);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({buf_en, buf_addr, dout_valid, busy} !== 7'd0) begin
      mismatched++;
      $display("[TB] FAIL idle_after_reset: got en=%b addr=%0d v=%b busy=%b expected all zero",
               buf_en, buf_addr, dout_valid, busy);
    end
  endtask

  task automatic test_basic();
    $display("[TB] test_basic");
    load_iv();
    run_readout(-1, 0, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    load_iv();
    run_readout(2, 5, 0, -1, -1);
  endtask

  task automatic test_overrun();
    $display("[TB] test_overrun");
    load_iv();
    run_readout(-1, 0, 0, 3, -1);
    load_iv();
    run_readout(-1, 0, 0, -1, -1);
    load_random();
    run_readout(-1, 0, 0, 7, -1);
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    load_iv();
    run_readout(-1, 0, 0, -1, 5);
    load_iv();
    run_readout(-1, 0, 0, -1, -1);
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    for (int n = 0; n < 4; n++) begin
      load_random();
      run_readout(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), 1,
                  (n % 2 == 1) ? int'($urandom_range(0, 7)) : -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
